// File: rtl/io_spi_bridge_pkg.sv
// Shared definitions for the PCMCIA I/O-space to SPI master bridge.
// Register offsets, status bit positions, shifter states and host capture bundle.
package io_spi_bridge_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_RXF   = 1;
    localparam int STAT_OVR   = 2;
    localparam int STAT_SS    = 6;
    localparam int STAT_INTEN = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic       ce1;
        logic       reg_n;
        logic [1:0] a;
        logic [7:0] d;
    } host_cap_t;

    function automatic logic [7:0] stat_byte(
        input logic inten,
        input logic ss,
        input logic ovr,
        input logic rxf,
        input logic busy
    );
        logic [7:0] v;
        v = 8'h00;
        v[STAT_INTEN] = inten;
        v[STAT_SS]    = ss;
        v[STAT_OVR]   = ovr;
        v[STAT_RXF]   = rxf;
        v[STAT_BUSY]  = busy;
        return v;
    endfunction

endpackage

// File: rtl/io_spi_bridge_shifter.sv
// Mode-0 SPI byte engine: half-period divider, transfer FSM, TX/RX shift
// registers and the registered SCLK/MOSI pins.
module spi_shifter
    import io_spi_bridge_pkg::*;
(
    input  logic       clk_26,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_tx,
    input  logic [7:0] i_div,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rx
);

    spi_state_e r_state;
    spi_state_e w_state_nxt;

    logic [7:0] r_cnt;
    logic [3:0] r_half;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic       r_sclk;
    logic       r_mosi;
    logic       w_tick;

    assign w_tick = (r_cnt == 8'd0);

    always_ff @(posedge clk_26) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_tick && r_half == 4'd15) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The divider reloads from the live DIV value at every half-period end,
    // so a DIV write mid-transfer applies from the next half-period.
    always_ff @(posedge clk_26) begin
        if (i_rst) begin
            r_cnt  <= 8'd0;
            r_half <= 4'd0;
            r_tx   <= 8'd0;
            r_rx   <= 8'd0;
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_tx   <= i_tx;
                        r_mosi <= i_tx[7];
                    end
                end
                ST_LOAD: begin
                    r_cnt  <= i_div;
                    r_half <= 4'd0;
                end
                ST_SHIFT: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_cnt  <= i_div;
                        r_half <= r_half + 4'd1;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                            r_rx   <= {r_rx[6:0], i_miso};
                        end else begin
                            r_sclk <= 1'b0;
                            r_tx   <= {r_tx[6:0], 1'b0};
                            r_mosi <= r_tx[6];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_rx   = r_rx;

endmodule

// File: rtl/io_spi_bridge.sv
// PCMCIA I/O-space register window onto a mode-0 SPI master.
// Holds the strobe synchronisers, register file, read mux and interrupt.
module io_spi_bridge
    import io_spi_bridge_pkg::*;
#(
    parameter logic [7:0] DIV_RESET   = 8'd12,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_26,
    input  logic       RESET,
    input  logic [1:0] A,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       io_ddir,
    output logic       INPACK,
    input  logic       IOWR,
    input  logic       IORD,
    input  logic       CE1,
    input  logic       REG,
    output logic       SS,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       INT
);

    logic [SYNC_STAGES-1:0] r_iowr_sync;
    logic [SYNC_STAGES-1:0] r_iord_sync;
    logic                   r_iowr_d;
    logic                   r_iord_d;
    host_cap_t              r_wcap;
    logic [3:0]             r_rcap;

    logic [7:0] r_rx;
    logic [7:0] r_div;
    logic       r_rxf;
    logic       r_ovr;
    logic       r_inten;
    logic       r_ss;
    logic       r_int;

    logic       w_iowr_s;
    logic       w_iord_s;
    logic       w_wr;
    logic       w_wr_data;
    logic       w_wr_ctrl;
    logic       w_wr_div;
    logic       w_start;
    logic       w_drop;
    logic       w_rd_clr;
    logic       w_busy;
    logic       w_done;
    logic [7:0] w_shift_rx;
    logic       w_rxf_nxt;
    logic       w_ovr_nxt;
    logic       w_inten_nxt;
    logic [7:0] w_rd_data;

    assign w_iowr_s = r_iowr_sync[SYNC_STAGES-1];
    assign w_iord_s = r_iord_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_26) begin
        if (RESET) begin
            r_iowr_sync <= '1;
            r_iord_sync <= '1;
            r_iowr_d    <= 1'b1;
            r_iord_d    <= 1'b1;
            r_wcap      <= '0;
            r_rcap      <= '0;
        end else begin
            r_iowr_sync <= {r_iowr_sync[SYNC_STAGES-2:0], IOWR};
            r_iord_sync <= {r_iord_sync[SYNC_STAGES-2:0], IORD};
            r_iowr_d    <= w_iowr_s;
            r_iord_d    <= w_iord_s;
            if (!w_iowr_s) begin
                r_wcap <= {CE1, REG, A, D_in};
            end
            if (!w_iord_s) begin
                r_rcap <= {CE1, REG, A};
            end
        end
    end

    // Commit on the synced strobe's trailing edge, using the last capture.
    assign w_wr      = w_iowr_s & ~r_iowr_d & ~r_wcap.ce1 & ~r_wcap.reg_n;
    assign w_wr_data = w_wr & (r_wcap.a == REG_DATA);
    assign w_wr_ctrl = w_wr & (r_wcap.a == REG_CTRL);
    assign w_wr_div  = w_wr & (r_wcap.a == REG_DIV);
    assign w_start   = w_wr_data & ~w_busy;
    assign w_drop    = w_wr_data & w_busy;
    assign w_rd_clr  = w_iord_s & ~r_iord_d & (r_rcap == {1'b0, 1'b0, REG_DATA});

    always_comb begin
        w_rxf_nxt   = r_rxf;
        w_ovr_nxt   = r_ovr;
        w_inten_nxt = r_inten;
        if (w_rd_clr) begin
            w_rxf_nxt = 1'b0;
        end
        if (w_done) begin
            w_rxf_nxt = 1'b1;
        end
        if (w_wr_ctrl) begin
            w_inten_nxt = r_wcap.d[STAT_INTEN];
            if (r_wcap.d[STAT_OVR]) begin
                w_ovr_nxt = 1'b0;
            end
        end
        if (w_drop || (w_done && r_rxf)) begin
            w_ovr_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_26) begin
        if (RESET) begin
            r_rx    <= 8'h00;
            r_div   <= DIV_RESET;
            r_rxf   <= 1'b0;
            r_ovr   <= 1'b0;
            r_inten <= 1'b0;
            r_ss    <= 1'b1;
            r_int   <= 1'b1;
        end else begin
            r_rxf   <= w_rxf_nxt;
            r_ovr   <= w_ovr_nxt;
            r_inten <= w_inten_nxt;
            r_int   <= ~(w_inten_nxt & w_rxf_nxt);
            if (w_done) begin
                r_rx <= w_shift_rx;
            end
            if (w_wr_ctrl) begin
                r_ss <= r_wcap.d[STAT_SS];
            end
            if (w_wr_div) begin
                r_div <= r_wcap.d;
            end
        end
    end

    spi_shifter u_shifter (
        .clk_26  (clk_26),
        .i_rst   (RESET),
        .i_start (w_start),
        .i_tx    (r_wcap.d),
        .i_div   (r_div),
        .i_miso  (MISO),
        .o_sclk  (SCLK),
        .o_mosi  (MOSI),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_rx    (w_shift_rx)
    );

    always_comb begin
        w_rd_data = 8'h00;
        case (A)
            REG_DATA: w_rd_data = r_rx;
            REG_CTRL: w_rd_data = stat_byte(r_inten, r_ss, r_ovr, r_rxf, w_busy);
            REG_DIV:  w_rd_data = r_div;
            default:  w_rd_data = 8'h00;
        endcase
    end

    assign io_ddir = ~CE1 & ~REG & ~IORD;
    assign INPACK  = ~io_ddir;
    assign D_out   = io_ddir ? w_rd_data : 8'h00;
    assign SS      = r_ss;
    assign INT     = r_int;

endmodule
